mux_sel_arbiter: RTL and testbench

Two-source registered arbiter that sits directly upstream of the 2:1 mux stage, feeding its A, B and SEL inputs. It accepts words from two valid/ready sources, registers the winning word into that source's holding register, and drives a registered SEL plus OUT_VALID. The downstream mux (a bank of MUX2_1, one per bit) therefore sees only flop-launched, glitch-free inputs. Arbitration is round-robin by default, with a compile-time fixed-priority option.

---
 rtl/mux_sel_pkg.sv | 19 +
 rtl/mux_sel_arbiter_rr_pick2.sv | 40 ++++
 rtl/mux_sel_arbiter.sv | 98 +++++++++
 tb/tb_mux_sel_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_sel_pkg.sv
// Shared types for the registered 2:1 mux-select arbiter.
// States, source ids and SEL encodings.
package mux_sel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD_A,
    HOLD_B
  } state_t;

  typedef enum logic {
    SRC_A,
    SRC_B
  } src_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_sel_arbiter_rr_pick2.sv
// rr_pick2: combinational two-request chooser, one-hot grants.
// Ports: a_valid, b_valid, last, en in; gnt_a, gnt_b out.
// MUX_SEL_FIXED_PRIO_EN: A always wins contention (last ignored).
import mux_sel_pkg::*;

module rr_pick2 (
  input  logic a_valid,
  input  logic b_valid,
  input  src_t last,
  input  logic en,
  output logic gnt_a,
  output logic gnt_b
);

  logic a_first;

`ifdef MUX_SEL_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = (last == SRC_B);
  assign a_first     = 1'b1;
`else
  // Under contention the source that did not win last time goes.
  assign a_first = (last == SRC_B);
`endif

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      if (a_valid && b_valid) begin
        gnt_a = a_first;
        gnt_b = !a_first;
      end else begin
        gnt_a = a_valid;
        gnt_b = b_valid;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Registered arbiter feeding A, B and SEL of a 2:1 mux bank.
// Ports: CLK, RST, A/B valid-data-ready, A_Q, B_Q, SEL, OUT_VALID/READY, XFER_CNT.
// Build option MUX_SEL_FIXED_PRIO_EN selects fixed priority (in rr_pick2).
import mux_sel_pkg::*;

module mux_sel_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             A_VALID,
  input  logic [WIDTH-1:0] A_DATA,
  output logic             A_READY,
  input  logic             B_VALID,
  input  logic [WIDTH-1:0] B_DATA,
  output logic             B_READY,
  output logic [WIDTH-1:0] A_Q,
  output logic [WIDTH-1:0] B_Q,
  output logic             SEL,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [CNT_W-1:0] XFER_CNT
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  src_t             last;
  logic             out_valid;
  logic             sel;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CNT_W-1:0] cnt;

  logic load;
  logic gnt_a;
  logic gnt_b;

  // Slot frees when empty or when the held word leaves this cycle.
  assign load = (state == IDLE) || OUT_READY;

  rr_pick2 u_pick (
    .a_valid (A_VALID),
    .b_valid (B_VALID),
    .last    (last),
    .en      (load && !RST),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b)
  );

  assign A_READY   = gnt_a;
  assign B_READY   = gnt_b;
  assign A_Q       = a_q;
  assign B_Q       = b_q;
  assign SEL       = sel;
  assign OUT_VALID = out_valid;
  assign XFER_CNT  = cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      last      <= SRC_B;
      out_valid <= 1'b0;
      sel       <= SEL_A;
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
    end else begin
      if (out_valid && OUT_READY && cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
      unique case (1'b1)
        gnt_a: begin
          a_q       <= A_DATA;
          sel       <= SEL_A;
          last      <= SRC_A;
          state     <= HOLD_A;
          out_valid <= 1'b1;
        end
        gnt_b: begin
          b_q       <= B_DATA;
          sel       <= SEL_B;
          last      <= SRC_B;
          state     <= HOLD_B;
          out_valid <= 1'b1;
        end
        default: begin
          // Free slot with nothing to take: go empty, keep SEL/data.
          if (load) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboard bench for mux_sel_arbiter with a reference model.
// Driver predicts accepts; monitor checks each delivered word.
module tb_mux_sel_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       A_VALID = 1'b0;
  logic [7:0] A_DATA = '0;
  logic       A_READY;
  logic       B_VALID = 1'b0;
  logic [7:0] B_DATA = '0;
  logic       B_READY;
  logic [7:0] A_Q;
  logic [7:0] B_Q;
  logic       SEL;
  logic       OUT_VALID;
  logic       OUT_READY = 1'b0;
  logic [7:0] XFER_CNT;

  mux_sel_arbiter dut (
    .CLK       (CLK),
    .RST       (RST),
    .A_VALID   (A_VALID),
    .A_DATA    (A_DATA),
    .A_READY   (A_READY),
    .B_VALID   (B_VALID),
    .B_DATA    (B_DATA),
    .B_READY   (B_READY),
    .A_Q       (A_Q),
    .B_Q       (B_Q),
    .SEL       (SEL),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .XFER_CNT  (XFER_CNT)
  );

  always #10 CLK = ~CLK;

  // Downstream mux: passes A when SEL=0.
  logic [7:0] mux_y;
  assign mux_y = SEL ? B_Q : A_Q;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: expected words as {sel, data}, in delivery order.
  logic [8:0] exp_q[$];
  bit m_valid = 0;
  bit m_last_b = 1;
  int m_cnt = 0;
  bit armed = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc(input bit rst,
                     input bit av, input logic [7:0] ad,
                     input bit bv, input logic [7:0] bd,
                     input bit ordy);
    bit load, pa, pb;
    @(posedge CLK);
    #1;
    RST = rst;
    A_VALID = av; A_DATA = ad;
    B_VALID = bv; B_DATA = bd;
    OUT_READY = ordy;
    #12;
    load = !m_valid || ordy;
    pa = 0;
    pb = 0;
    if (!rst && load) begin
      if (av && bv) begin
`ifdef MUX_SEL_FIXED_PRIO_EN
        pa = 1;
`else
        if (m_last_b) pa = 1;
        else pb = 1;
`endif
      end else begin
        pa = av;
        pb = bv;
      end
    end
    chk("a_ready", {31'b0, A_READY}, {31'b0, pa});
    chk("b_ready", {31'b0, B_READY}, {31'b0, pb});
    if (armed) begin
      chk("out_valid", {31'b0, OUT_VALID}, {31'b0, m_valid});
      chk("xfer_cnt", {24'b0, XFER_CNT}, m_cnt);
    end
    if (rst) begin
      m_valid = 0;
      m_last_b = 1;
      m_cnt = 0;
      exp_q.delete();
      armed = 1;
    end else begin
      if (m_valid && ordy && m_cnt < 255) m_cnt++;
      if (pa) begin
        exp_q.push_back({1'b0, ad});
        m_valid = 1;
        m_last_b = 0;
      end else if (pb) begin
        exp_q.push_back({1'b1, bd});
        m_valid = 1;
        m_last_b = 1;
      end else if (load) begin
        m_valid = 0;
      end
    end
  endtask

  // Monitor: every handshake must deliver the oldest expected word.
  initial begin
    logic [8:0] e;
    forever begin
      @(posedge CLK);
      #14;
      if (!RST && OUT_VALID === 1'b1 && OUT_READY) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {23'b0, SEL, mux_y}, 32'h1ff);
        end else begin
          e = exp_q.pop_front();
          chk("sel", {31'b0, SEL}, {31'b0, e[8]});
          chk("mux_out", {24'b0, mux_y}, {24'b0, e[7:0]});
        end
      end
    end
  end

  initial begin
    // Reset with both sources requesting.
    cyc(1, 1, 8'h11, 1, 8'h22, 1);
    cyc(1, 1, 8'h11, 1, 8'h22, 1);
    chk("rst_sel", {31'b0, SEL}, 0);
    chk("rst_a_q", {24'b0, A_Q}, 0);
    chk("rst_b_q", {24'b0, B_Q}, 0);
    chk("rst_cnt", {24'b0, XFER_CNT}, 0);
    // First contention after reset goes to A.
    cyc(0, 1, 8'h01, 1, 8'h02, 1);
    cyc(0, 0, 8'h00, 0, 8'h00, 1);
    cyc(1, 0, 8'h00, 0, 8'h00, 0);

    // Single source A.
    cyc(0, 1, 8'h3c, 0, 8'h00, 1);
    cyc(0, 1, 8'h5a, 0, 8'h00, 1);
    chk("single_a_q1", {24'b0, A_Q}, 32'h3c);
    cyc(0, 0, 8'h00, 0, 8'h00, 1);
    chk("single_a_q2", {24'b0, A_Q}, 32'h5a);
    chk("single_sel", {31'b0, SEL}, 0);
    cyc(0, 0, 8'h00, 0, 8'h00, 1);
    chk("single_cnt", {24'b0, XFER_CNT}, 2);

    // Contention, six cycles.
    for (int i = 0; i < 6; i++)
      cyc(0, 1, 8'ha0 + 8'(i), 1, 8'hb0 + 8'(i), 1);
    cyc(0, 0, 8'h00, 0, 8'h00, 1);

    // Back-pressure while B word held.
    cyc(0, 0, 8'h00, 1, 8'h77, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 8'h99, 0, 8'h00, 0);
      chk("bp_sel", {31'b0, SEL}, 1);
      chk("bp_b_q", {24'b0, B_Q}, 32'h77);
    end
    cyc(0, 1, 8'h99, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 0, 8'h00, 1);
    chk("bp_sel_after", {31'b0, SEL}, 0);
    chk("bp_a_q_after", {24'b0, A_Q}, 32'h99);

    // Reset while holding a B word.
    cyc(0, 0, 8'h00, 1, 8'h4e, 0);
    cyc(1, 0, 8'h00, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 0, 8'h00, 0);
    chk("mid_rst_valid", {31'b0, OUT_VALID}, 0);
    chk("mid_rst_a_q", {24'b0, A_Q}, 0);
    chk("mid_rst_b_q", {24'b0, B_Q}, 0);
    chk("mid_rst_cnt", {24'b0, XFER_CNT}, 0);

    // Saturation: 300+ handshakes.
    for (int i = 0; i < 305; i++)
      cyc(0, 1, 8'(i), (i % 3) == 0, 8'(i + 7), 1);
    cyc(0, 0, 8'h00, 0, 8'h00, 1);
    chk("sat_cnt", {24'b0, XFER_CNT}, 255);
    cyc(0, 0, 8'h00, 0, 8'h00, 1);
    chk("sat_hold", {24'b0, XFER_CNT}, 255);

    // Randomized traffic with occasional reset.
    cyc(1, 0, 8'h00, 0, 8'h00, 0);
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 59) == 0,
          $urandom_range(0, 1) == 1, 8'($urandom),
          $urandom_range(0, 1) == 1, 8'($urandom),
          $urandom_range(0, 9) < 7);
    cyc(0, 0, 8'h00, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 0, 8'h00, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
